// File: rtl/affine_pkg.sv
// Shared types for the picoMIPS affine front-end sequencer.
// Sequencer state encoding, default word width and the signed coordinate type.
package affine_pkg;

    localparam int DATALENGTH_DEF = 8;

    typedef logic signed [7:0] coord_t;

    typedef enum logic [2:0] {
        WAIT_X,
        LOAD_X,
        WAIT_Y,
        LOAD_Y,
        START,
        COMPUTE,
        SHOW_WAIT,
        SHOW_X
    } seq_state_t;

endpackage

// File: rtl/affine_io_sequencer_if.sv
// Board-facing and datapath-facing signals of the affine sequencer.
// master = the sequencer itself, slave = switches/LEDs plus the datapath.
interface affine_io_sequencer_if #(
    parameter int DATALENGTH = affine_pkg::DATALENGTH_DEF
);
    logic [8:0]            SW;
    logic [DATALENGTH-1:0] x1;
    logic [DATALENGTH-1:0] y1;
    logic                  start;
    logic                  done;
    logic [DATALENGTH-1:0] x2;
    logic [DATALENGTH-1:0] y2;
    logic [DATALENGTH-1:0] dataout;
    logic                  busy;
    logic                  err;

    modport master (
        input  SW, done, x2, y2,
        output x1, y1, start, dataout, busy, err
    );

    modport slave (
        output SW, done, x2, y2,
        input  x1, y1, start, dataout, busy, err
    );
endinterface

// File: rtl/affine_io_sequencer_sw_edge_sync.sv
// Switch synchronizer with strobe edge detection; SW[8:0] travels as one vector.
// Define AFFINE_SEQ_DEBOUNCE_EN to filter the strobe through a DEBOUNCE_CYCLES counter.
module sw_edge_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] sw_in,
    output logic [7:0] data,
    output logic       rise,
    output logic       fall
);
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("sw_edge_sync: needs SYNC_STAGES >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0][8:0] sync_q, sync_d;
    logic                        sync8;
    logic                        strobe;
    logic                        prev_q;

    always_comb begin
        sync_d = '0;
        sync_d[0] = sw_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= strobe;
        end
    end

    assign sync8 = sync_q[SYNC_STAGES-1][8];
    assign data  = sync_q[SYNC_STAGES-1][7:0];

`ifdef AFFINE_SEQ_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

    logic            filt_q, filt_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // Counter tracks consecutive cycles where the synced strobe disagrees with the filtered one.
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = '0;
        if (sync8 != filt_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                filt_d = sync8;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            filt_q   <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign strobe = filt_q;
`else
    assign strobe = sync8;
`endif

    assign rise = strobe & ~prev_q;
    assign fall = ~strobe & prev_q;

endmodule

// File: rtl/affine_io_sequencer.sv
// SW[8] handshake sequencer: capture x1/y1, pulse start, await done, show x2/y2 on LEDs.
// Optional strobe debounce is enabled with AFFINE_SEQ_DEBOUNCE_EN (see sw_edge_sync).
module affine_io_sequencer
    import affine_pkg::*;
#(
    parameter int datalength      = DATALENGTH_DEF,
    parameter int SYNC_STAGES     = 2,
    parameter int TIMEOUT         = 255,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    affine_io_sequencer_if.master io
);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    seq_state_t            state_q, state_d;
    logic [datalength-1:0] x1_q, x1_d;
    logic [datalength-1:0] y1_q, y1_d;
    logic [datalength-1:0] dout_q, dout_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [7:0]            sw_data;
    coord_t                sw_coord;
    logic [datalength-1:0] sw_word;
    logic                  rise;
    logic                  fall;

    sw_edge_sync #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_edge_sync (
        .clk  (clk),
        .rst  (rst),
        .sw_in(io.SW),
        .data (sw_data),
        .rise (rise),
        .fall (fall)
    );

    // Switch data is signed; widen with sign extension if datalength exceeds 8.
    assign sw_coord = coord_t'(sw_data);
    assign sw_word  = datalength'(sw_coord);

    always_comb begin
        state_d = state_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        dout_d  = dout_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_X: if (rise) state_d = LOAD_X;
            LOAD_X: begin
                dout_d = sw_word;
                if (fall) begin
                    x1_d    = sw_word;
                    err_d   = 1'b0;
                    state_d = WAIT_Y;
                end
            end
            WAIT_Y: if (rise) state_d = LOAD_Y;
            LOAD_Y: begin
                dout_d = sw_word;
                if (fall) begin
                    y1_d    = sw_word;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = COMPUTE;
            end
            COMPUTE: begin
                cnt_d = cnt_q + 1'b1;
                // done takes priority over a timeout expiring in the same cycle
                if (io.done) begin
                    state_d = SHOW_WAIT;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    dout_d  = '0;
                    state_d = WAIT_X;
                end
            end
            SHOW_WAIT: begin
                if (rise) begin
                    dout_d  = io.x2;
                    state_d = SHOW_X;
                end
            end
            SHOW_X: begin
                if (fall) begin
                    dout_d  = io.y2;
                    state_d = WAIT_X;
                end
            end
            default: state_d = WAIT_X;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= WAIT_X;
            x1_q    <= '0;
            y1_q    <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign io.x1      = x1_q;
    assign io.y1      = y1_q;
    assign io.dataout = dout_q;
    assign io.err     = err_q;
    assign io.start   = (state_q == START);
    assign io.busy    = (state_q == START) || (state_q == COMPUTE);

endmodule

// File: tb/tb_affine_io_sequencer.sv
// Directed bench for affine_io_sequencer: capture, display, timeout, glitch and reset cases.
// Debounce-specific pulses are exercised when AFFINE_SEQ_DEBOUNCE_EN is defined.
module tb_affine_io_sequencer;
    import affine_pkg::*;

    localparam int SYNC_STAGES     = 2;
    localparam int TIMEOUT         = 255;
    localparam int DEBOUNCE_CYCLES = 4;
`ifdef AFFINE_SEQ_DEBOUNCE_EN
    localparam int EDGE_LAT = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
`else
    localparam int EDGE_LAT = SYNC_STAGES + 1;
`endif
    localparam int HOLD = EDGE_LAT + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   start_pulses = 0;
    int   start_mark = 0;

    affine_io_sequencer_if #(.DATALENGTH(8)) io ();

    affine_io_sequencer #(
        .datalength     (8),
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT        (TIMEOUT),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (io.start === 1'b1) start_pulses++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sw_drive(input logic [8:0] v, input int n);
        io.SW = v;
        tick(n);
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %-14s = %0h", tag, got);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        io.SW = 9'h1FF; io.done = 1'b0; io.x2 = 8'h00; io.y2 = 8'h00;
        rst = 1'b0;
        tick(2);
        check_val("rst_state", 32'(dut.state_q), 32'(WAIT_X));
        check_val("rst_x1", 32'(io.x1), 32'h0);
        check_val("rst_y1", 32'(io.y1), 32'h0);
        check_val("rst_dataout", 32'(io.dataout), 32'h0);
        check_val("rst_start", 32'(io.start), 32'h0);
        check_val("rst_busy", 32'(io.busy), 32'h0);
        check_val("rst_err", 32'(io.err), 32'h0);
        io.SW = 9'h000;
        rst = 1'b1;
        tick(HOLD);
        check_val("idle_state", 32'(dut.state_q), 32'(WAIT_X));

        // first transaction: x1 = 0x18, y1 = 0xEE
        sw_drive(9'h100, HOLD);
        check_val("load_x_state", 32'(dut.state_q), 32'(LOAD_X));
        sw_drive(9'h118, HOLD);
        check_val("echo_x", 32'(io.dataout), 32'h18);
        sw_drive(9'h018, HOLD);
        check_val("x1_cap", 32'(io.x1), 32'h18);
        check_val("wait_y_state", 32'(dut.state_q), 32'(WAIT_Y));
        io.done = 1'b1; tick(1); io.done = 1'b0; tick(1);
        check_val("stray_done", 32'(dut.state_q), 32'(WAIT_Y));
        sw_drive(9'h1D8, HOLD);
        sw_drive(9'h1EE, HOLD);
        check_val("echo_y", 32'(io.dataout), 32'hEE);
        start_mark = start_pulses;
        io.SW = 9'h0EE;
        tick(EDGE_LAT - 1);
        check_val("start_early", 32'(io.start), 32'h0);
        tick(1);
        check_val("start_lat", 32'(io.start), 32'h1);
        check_val("busy_start", 32'(io.busy), 32'h1);
        check_val("y1_cap", 32'(io.y1), 32'hEE);
        tick(1);
        check_val("start_1cyc", 32'(io.start), 32'h0);
        check_val("busy_comp", 32'(io.busy), 32'h1);
        sw_drive(9'h1EE, 1);
        sw_drive(9'h0EE, HOLD);
        check_val("glitch_comp", 32'(dut.state_q), 32'(COMPUTE));
        tick(12);
        io.x2 = 8'h2A; io.y2 = 8'hF3; io.done = 1'b1;
        tick(1);
        io.done = 1'b0;
        check_val("show_wait", 32'(dut.state_q), 32'(SHOW_WAIT));
        check_val("busy_done", 32'(io.busy), 32'h0);
        check_val("dout_hold", 32'(io.dataout), 32'hEE);
        check_val("start_count", 32'(start_pulses - start_mark), 32'h1);
        sw_drive(9'h100, HOLD);
        check_val("show_x2", 32'(io.dataout), 32'h2A);
        sw_drive(9'h000, HOLD);
        check_val("show_y2", 32'(io.dataout), 32'hF3);
        check_val("show_end", 32'(dut.state_q), 32'(WAIT_X));

        // second transaction: x1 = 0x0F, y1 = 0xE1
        io.SW = 9'h10F;
        tick(EDGE_LAT);
        check_val("y2_persist", 32'(io.dataout), 32'hF3);
        tick(1);
        check_val("echo_x_2", 32'(io.dataout), 32'h0F);
        tick(1);
        sw_drive(9'h00F, HOLD);
        check_val("x1_cap_2", 32'(io.x1), 32'h0F);
        sw_drive(9'h1E1, HOLD);
        sw_drive(9'h0E1, HOLD);
        check_val("y1_cap_2", 32'(io.y1), 32'hE1);
        check_val("err_2", 32'(io.err), 32'h0);
        io.done = 1'b1; tick(1); io.done = 1'b0;
        check_val("done_2", 32'(dut.state_q), 32'(SHOW_WAIT));
        sw_drive(9'h100, HOLD);
        sw_drive(9'h000, HOLD);

        // timeout: done never arrives
        sw_drive(9'h133, HOLD);
        sw_drive(9'h033, HOLD);
        sw_drive(9'h144, HOLD);
        io.SW = 9'h044;
        tick(EDGE_LAT);
        check_val("to_start", 32'(io.start), 32'h1);
        tick(TIMEOUT + 1);
        check_val("to_last_busy", 32'(io.busy), 32'h1);
        check_val("to_last_err", 32'(io.err), 32'h0);
        tick(1);
        check_val("to_busy", 32'(io.busy), 32'h0);
        check_val("to_err", 32'(io.err), 32'h1);
        check_val("to_dataout", 32'(io.dataout), 32'h0);
        check_val("to_state", 32'(dut.state_q), 32'(WAIT_X));

        // next x1 capture clears err; done on the timeout cycle wins
        sw_drive(9'h155, HOLD);
        check_val("err_kept", 32'(io.err), 32'h1);
        sw_drive(9'h055, HOLD);
        check_val("err_clear", 32'(io.err), 32'h0);
        sw_drive(9'h166, HOLD);
        io.SW = 9'h066;
        tick(EDGE_LAT);
        tick(TIMEOUT + 1);
        io.done = 1'b1; tick(1); io.done = 1'b0;
        check_val("done_wins", 32'(dut.state_q), 32'(SHOW_WAIT));
        check_val("done_wins_err", 32'(io.err), 32'h0);
        sw_drive(9'h100, HOLD);
        sw_drive(9'h000, HOLD);
        check_val("back_idle", 32'(dut.state_q), 32'(WAIT_X));

`ifdef AFFINE_SEQ_DEBOUNCE_EN
        sw_drive(9'h100, 3);
        sw_drive(9'h000, HOLD + 2);
        check_val("db_reject3", 32'(dut.state_q), 32'(WAIT_X));
        sw_drive(9'h17A, 4);
        sw_drive(9'h07A, HOLD + 4);
        check_val("db_accept4", 32'(dut.state_q), 32'(WAIT_Y));
        check_val("db_x1", 32'(io.x1), 32'h7A);
`else
        sw_drive(9'h15A, 1);
        sw_drive(9'h05A, HOLD);
        check_val("glitch_edge", 32'(dut.state_q), 32'(WAIT_Y));
        check_val("glitch_x1", 32'(io.x1), 32'h5A);
`endif

        // reset on the cycle the final fall would launch start
        sw_drive(9'h1AA, HOLD);
        start_mark = start_pulses;
        io.SW = 9'h0AA;
        tick(EDGE_LAT - 1);
        rst = 1'b0;
        tick(1);
        check_val("mid_rst_state", 32'(dut.state_q), 32'(WAIT_X));
        check_val("mid_rst_start", 32'(io.start), 32'h0);
        check_val("mid_rst_x1", 32'(io.x1), 32'h0);
        check_val("mid_rst_dout", 32'(io.dataout), 32'h0);
        rst = 1'b1;
        tick(HOLD);
        check_val("no_late_start", 32'(start_pulses - start_mark), 32'h0);
        check_val("post_rst", 32'(dut.state_q), 32'(WAIT_X));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
